bs_turn_ctrl: RTL and testbench

- Sequences Battleship gameplay between two players and owns the shared shot datapath.
- Arbitrates fire requests by turn and latches the active player's coordinate into the shot register.
- Issues a query to the board-lookup block, scores the result, holds it for display, then hands the turn over.
- Sits between the debounced player inputs and the board memory / score display logic.

---
 rtl/bs_pkg.sv | 27 ++
 rtl/bs_hold_timer.sv | 38 +++
 rtl/bs_register.sv | 25 ++
 rtl/bs_turn_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_bs_turn_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bs_pkg.sv
// Shared types and constants for the Battleship turn controller slice.
package bs_pkg;

   // Bits per row/column coordinate on the 8x8 grid.
   localparam int unsigned GRID_COORD_W    = 3;
   // Default hit count that ends a game (total ship cells on one board).
   localparam int unsigned HITS_TO_WIN_DEF = 9;

   typedef logic player_t;

   typedef enum logic [2:0] {
      StIdle,
      StQuery,
      StWait,
      StResult,
      StOver
   } bs_state_e;

   // Outcome of the last board query, shown while in StResult.
   typedef enum logic [1:0] {
      ResNone,
      ResHit,
      ResMiss,
      ResDup
   } bs_res_e;

endpackage

// File: rtl/bs_hold_timer.sv
// Result-hold timer: load to HOLD_CYC-1, count down, flag expiry at zero.
module bs_hold_timer #(
   parameter int unsigned HOLD_CYC = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic load_i,
   input  logic dec_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(HOLD_CYC + 1);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   // Load has priority; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CntW'(HOLD_CYC - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // Counter state.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/bs_register.sv
// Generic enable register with asynchronous active-low clear.
module bs_register #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] val_q;

   // Capture d_i when enabled; cleared asynchronously.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         val_q <= '0;
      end else if (en_i) begin
         val_q <= d_i;
      end
   end

   assign q_o = val_q;

endmodule

// File: rtl/bs_turn_ctrl.sv
// Battleship turn sequencer: arbitrates fire by turn, queries the board,
// scores and holds the result, then hands over the turn.
module bs_turn_ctrl
   import bs_pkg::*;
#(
   parameter int unsigned COORD_W     = GRID_COORD_W,
   parameter int unsigned HITS_TO_WIN = HITS_TO_WIN_DEF,
   parameter int unsigned SCORE_W     = 4,
   parameter int unsigned HOLD_CYC    = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [1:0]         fire_i,
   input  logic [COORD_W-1:0] p0_row_i,
   input  logic [COORD_W-1:0] p0_col_i,
   input  logic [COORD_W-1:0] p1_row_i,
   input  logic [COORD_W-1:0] p1_col_i,
   input  logic               new_game_i,
   output logic               q_valid_o,
   output logic               q_board_o,
   output logic [COORD_W-1:0] q_row_o,
   output logic [COORD_W-1:0] q_col_o,
   input  logic               q_hit_i,
   input  logic               q_dup_i,
   output logic               turn_o,
   output logic               hit_flag_o,
   output logic               miss_flag_o,
   output logic               dup_flag_o,
   output logic [SCORE_W-1:0] score0_o,
   output logic [SCORE_W-1:0] score1_o,
   output logic               game_over_o,
   output logic               winner_o
);

   localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(HITS_TO_WIN);

   bs_state_e state_q, state_d;
   player_t   turn_q, turn_d;
   player_t   winner_q, winner_d;
   bs_res_e   res_q, res_d;

   logic                   shot_en;
   logic [2*COORD_W-1:0]   shot_d;
   logic [2*COORD_W-1:0]   shot_q;
   logic [1:0]             score_en;
   logic [SCORE_W-1:0]     score_d;
   logic [SCORE_W-1:0]     score_cur;
   logic                   fire_accept;
   logic                   win;
   logic                   tmr_load;
   logic                   tmr_dec;
   logic                   tmr_expired;

   assign fire_accept = (state_q == StIdle) && fire_i[turn_q];
   assign score_cur   = turn_q ? score1_o : score0_o;
   assign win         = (score_cur == WinScore);

   // Shot coordinate {row, col}, latched from the turn holder on accept.
   assign shot_d = turn_q ? {p1_row_i, p1_col_i} : {p0_row_i, p0_col_i};

   bs_register #(
      .Width (2 * COORD_W)
   ) u_shot_reg (
      .clk  (clk),
      .clr  (clr),
      .en_i (shot_en),
      .d_i  (shot_d),
      .q_o  (shot_q)
   );

   bs_register #(
      .Width (SCORE_W)
   ) u_score0_reg (
      .clk  (clk),
      .clr  (clr),
      .en_i (score_en[0]),
      .d_i  (score_d),
      .q_o  (score0_o)
   );

   bs_register #(
      .Width (SCORE_W)
   ) u_score1_reg (
      .clk  (clk),
      .clr  (clr),
      .en_i (score_en[1]),
      .d_i  (score_d),
      .q_o  (score1_o)
   );

   bs_hold_timer #(
      .HOLD_CYC (HOLD_CYC)
   ) u_hold_timer (
      .clk       (clk),
      .clr       (clr),
      .load_i    (tmr_load),
      .dec_i     (tmr_dec),
      .expired_o (tmr_expired)
   );

   // FSM state and turn bookkeeping registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= StIdle;
         turn_q   <= 1'b0;
         winner_q <= 1'b0;
         res_q    <= ResNone;
      end else begin
         state_q  <= state_d;
         turn_q   <= turn_d;
         winner_q <= winner_d;
         res_q    <= res_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (fire_accept) state_d = StQuery;
         StQuery:  state_d = StWait;
         StWait:   state_d = StResult;
         StResult: if (tmr_expired) state_d = win ? StOver : StIdle;
         StOver:   if (new_game_i) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath controls: latch shot, score, hold timer, turn hand-over.
   always_comb begin
      shot_en  = 1'b0;
      score_en = 2'b00;
      score_d  = score_cur;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      turn_d   = turn_q;
      winner_d = winner_q;
      res_d    = res_q;
      unique case (state_q)
         StIdle: begin
            shot_en = fire_accept;
         end
         StWait: begin
            tmr_load = 1'b1;
            if (q_dup_i) begin
               res_d = ResDup;
            end else if (q_hit_i) begin
               res_d = ResHit;
               // Saturate so the counter never wraps.
               if (score_cur != WinScore) begin
                  score_d          = score_cur + SCORE_W'(1);
                  score_en[turn_q] = 1'b1;
               end
            end else begin
               res_d = ResMiss;
            end
         end
         StResult: begin
            if (tmr_expired) begin
               res_d = ResNone;
               if (win) begin
                  winner_d = turn_q;
               end else if (res_q != ResDup) begin
                  turn_d = ~turn_q;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end
         StOver: begin
            if (new_game_i) begin
               score_d  = '0;
               score_en = 2'b11;
               turn_d   = 1'b0;
               winner_d = 1'b0;
               res_d    = ResNone;
            end
         end
         default: ;
      endcase
   end

   // Moore outputs decoded from state.
   always_comb begin
      q_valid_o   = (state_q == StQuery);
      q_board_o   = ~turn_q;
      hit_flag_o  = (state_q == StResult) && (res_q == ResHit);
      miss_flag_o = (state_q == StResult) && (res_q == ResMiss);
      dup_flag_o  = (state_q == StResult) && (res_q == ResDup);
      game_over_o = (state_q == StOver);
      winner_o    = winner_q;
      turn_o      = turn_q;
      q_row_o     = shot_q[2*COORD_W-1:COORD_W];
      q_col_o     = shot_q[COORD_W-1:0];
   end

endmodule

// File: tb/tb_bs_turn_ctrl.sv
// Self-checking bench for bs_turn_ctrl against a simple game model.
module tb_bs_turn_ctrl;

   localparam int CW   = 3;
   localparam int HITS = 9;
   localparam int SW   = 4;
   localparam int HOLD = 4;

   logic          clk = 1'b0;
   logic          clr = 1'b0;
   logic [1:0]    fire = 2'b00;
   logic [CW-1:0] p0_row = '0, p0_col = '0, p1_row = '0, p1_col = '0;
   logic          new_game = 1'b0;
   logic          q_valid, q_board;
   logic [CW-1:0] q_row, q_col;
   logic          q_hit = 1'b0, q_dup = 1'b0;
   logic          turn, hit_flag, miss_flag, dup_flag;
   logic [SW-1:0] score0, score1;
   logic          game_over, winner;

   int tests_run = 0;
   int failed    = 0;

   // Game model: whose turn, scores, and end-of-game state.
   int m_turn  = 0;
   int m_sc[2] = '{0, 0};
   bit m_over  = 1'b0;
   int m_win   = 0;

   always #5 clk = ~clk;

   bs_turn_ctrl #(
      .COORD_W     (CW),
      .HITS_TO_WIN (HITS),
      .SCORE_W     (SW),
      .HOLD_CYC    (HOLD)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .fire_i      (fire),
      .p0_row_i    (p0_row),
      .p0_col_i    (p0_col),
      .p1_row_i    (p1_row),
      .p1_col_i    (p1_col),
      .new_game_i  (new_game),
      .q_valid_o   (q_valid),
      .q_board_o   (q_board),
      .q_row_o     (q_row),
      .q_col_o     (q_col),
      .q_hit_i     (q_hit),
      .q_dup_i     (q_dup),
      .turn_o      (turn),
      .hit_flag_o  (hit_flag),
      .miss_flag_o (miss_flag),
      .dup_flag_o  (dup_flag),
      .score0_o    (score0),
      .score1_o    (score1),
      .game_over_o (game_over),
      .winner_o    (winner)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_turn  = 0;
      m_sc[0] = 0;
      m_sc[1] = 0;
      m_over  = 1'b0;
      m_win   = 0;
   endtask

   task automatic check_scores(input string tag);
      check({tag, "_score0"}, 32'(score0), 32'(m_sc[0]));
      check({tag, "_score1"}, 32'(score1), 32'(m_sc[1]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_q_valid"}, 32'(q_valid), 0);
      check({tag, "_turn"}, 32'(turn), 0);
      check({tag, "_q_row"}, 32'(q_row), 0);
      check({tag, "_q_col"}, 32'(q_col), 0);
      check({tag, "_flags"}, 32'({hit_flag, miss_flag, dup_flag}), 0);
      check({tag, "_game_over"}, 32'(game_over), 0);
      check({tag, "_winner"}, 32'(winner), 0);
      check_scores(tag);
   endtask

   // One complete shot by the current turn holder; the model must be in IDLE.
   task automatic shot(input logic [1:0] fv, input int r0, input int c0, input int r1,
                       input int c1, input bit hit, input bit dup);
      int er, ec;
      bit exp_hit, exp_miss, exp_dup;
      er = (m_turn == 1) ? r1 : r0;
      ec = (m_turn == 1) ? c1 : c0;
      fire   = fv;
      p0_row = CW'(r0);
      p0_col = CW'(c0);
      p1_row = CW'(r1);
      p1_col = CW'(c1);
      step();
      // QUERY: perturb fire and coordinates; neither may affect the shot.
      fire   = 2'($urandom_range(0, 3));
      p0_row = CW'($urandom);
      p1_col = CW'($urandom);
      check("query_q_valid", 32'(q_valid), 1);
      check("query_q_board", 32'(q_board), 32'(1 - m_turn));
      check("query_q_row", 32'(q_row), 32'(er));
      check("query_q_col", 32'(q_col), 32'(ec));
      q_hit = hit;
      q_dup = dup;
      step();
      // WAIT
      check("wait_q_valid", 32'(q_valid), 0);
      check("wait_flags", 32'({hit_flag, miss_flag, dup_flag}), 0);
      check("wait_q_row", 32'(q_row), 32'(er));
      step();
      fire  = 2'b00;
      q_hit = 1'b0;
      q_dup = 1'b0;
      exp_dup  = dup;
      exp_hit  = !dup && hit;
      exp_miss = !dup && !hit;
      if (exp_hit && m_sc[m_turn] < HITS) m_sc[m_turn]++;
      for (int i = 0; i < HOLD; i++) begin
         check("result_flags", 32'({hit_flag, miss_flag, dup_flag}),
               32'({exp_hit, exp_miss, exp_dup}));
         check("result_q_valid", 32'(q_valid), 0);
         check_scores("result");
         step();
      end
      if (m_sc[m_turn] == HITS) begin
         m_over = 1'b1;
         m_win  = m_turn;
      end else if (!dup) begin
         m_turn = 1 - m_turn;
      end
      check("after_flags", 32'({hit_flag, miss_flag, dup_flag}), 0);
      check("after_turn", 32'(turn), 32'(m_turn));
      check("after_game_over", 32'(game_over), 32'(m_over));
      if (m_over) check("after_winner", 32'(winner), 32'(m_win));
   endtask

   task automatic check_over_idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         fire = 2'($urandom_range(1, 3));
         step();
         check("over_q_valid", 32'(q_valid), 0);
         check("over_game_over", 32'(game_over), 1);
         check("over_winner", 32'(winner), 32'(m_win));
         check_scores("over");
      end
      fire = 2'b00;
   endtask

   task automatic start_new_game();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      model_reset();
      check("newgame_game_over", 32'(game_over), 0);
      check("newgame_turn", 32'(turn), 0);
      check_scores("newgame");
   endtask

   initial begin
      int guard;
      bit hit, dup;
      logic [1:0] fv;

      // Reset
      model_reset();
      #12;
      check_reset_outputs("reset");
      clr = 1'b1;
      step();

      // Non-turn player fires: ignored.
      fire   = 2'b10;
      p1_row = 3'd3;
      p1_col = 3'd4;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ignored_q_valid", 32'(q_valid), 0);
         check("ignored_turn", 32'(turn), 0);
      end
      fire = 2'b00;
      step();

      // Player 0 hits at (5,2).
      shot(2'b01, 5, 2, 1, 1, 1'b1, 1'b0);
      // Player 1 misses.
      shot(2'b10, 0, 7, 3, 4, 1'b0, 1'b0);
      // Duplicate with hit also set: dup only, turn kept, then re-fire with both bits.
      shot(2'b01, 6, 6, 2, 2, 1'b1, 1'b1);
      shot(2'b11, 1, 7, 4, 0, 1'b1, 1'b0);

      // Reset pulse while in WAIT; a late q_hit must be ignored.
      fire = 2'b01 << m_turn;
      step();
      fire = 2'b00;
      step();
      q_hit = 1'b1;
      #1 clr = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midreset");
      @(negedge clk);
      clr = 1'b1;
      step();
      q_hit = 1'b0;
      check("midreset_late_hit_score0", 32'(score0), 0);
      check("midreset_late_hit_flags", 32'({hit_flag, miss_flag, dup_flag}), 0);
      check("midreset_late_q_valid", 32'(q_valid), 0);

      // Random game until someone wins.
      guard = 0;
      while (!m_over && guard < 300) begin
         fv  = 2'b01 << m_turn;
         fv  = fv | 2'($urandom_range(0, 3));
         dup = ($urandom_range(0, 5) == 0);
         hit = ($urandom_range(0, 2) != 0);
         shot(fv, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), hit, dup);
         guard++;
      end
      check("random_game_ended", 32'(m_over), 1);
      check_over_idle(3);
      start_new_game();

      // Directed game: player 0 always hits, player 1 always misses.
      guard = 0;
      while (!m_over && guard < 40) begin
         shot(2'b01 << m_turn, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), (m_turn == 0), 1'b0);
         guard++;
      end
      check("p0_win_game_over", 32'(game_over), 1);
      check("p0_win_winner", 32'(winner), 0);
      check("p0_win_score0", 32'(score0), HITS);
      check_over_idle(4);
      start_new_game();
      // Game restarted: player 0 may fire again.
      shot(2'b01, 2, 3, 4, 5, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
